// File: rtl/stopwatch_top.sv
// Stopwatch MM:SS for the pseudo-terminal; STOP_ON_DESELECT_EN stops the count when deselected.
// Latency: counters update on the tick edge, display is combinational from registers.
// Backpressure: none; go is edge-detected and the display is always valid.
module stopwatch_top #(
    parameter int          TICK_DIV = 100000000,
    parameter logic [10:0] SEL_CODE = 11'b00001000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        go,
    input  logic [10:0] op_code,
    output logic [39:0] display
);

    localparam int            PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

    logic [PW-1:0] prescaler;
    logic [5:0]    sec;
    logic [5:0]    min;
    logic          run;
    logic          go_d;
    logic          sel;
    logic          go_rise;
    logic          tick;

    assign sel     = (op_code == SEL_CODE);
    assign go_rise = go & ~go_d & sel;
    assign tick    = run & (prescaler == PRE_MAX);

    // Binary value 0..59 rendered as two ASCII digits; digits are < 10 so OR equals add.
    function automatic logic [15:0] two_digits(input logic [5:0] v);
        logic [5:0] t;
        logic [5:0] o;
        t = v / 6'd10;
        o = v % 6'd10;
        return {8'h30 | {2'b00, t}, 8'h30 | {2'b00, o}};
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run       <= 1'b0;
            prescaler <= '0;
            sec       <= 6'd0;
            min       <= 6'd0;
            go_d      <= 1'b0;
        end else begin
            go_d <= go;
            if (tick) begin
                prescaler <= '0;
                if (sec == 6'd59) begin
                    sec <= 6'd0;
                    min <= (min == 6'd59) ? 6'd0 : min + 6'd1;
                end else begin
                    sec <= sec + 6'd1;
                end
            end else if (run) begin
                prescaler <= prescaler + 1'b1;
            end
            // The tick above already used the pre-edge run, so a same-edge stop still counts it.
`ifdef STOP_ON_DESELECT_EN
            if (!sel)
                run <= 1'b0;
            else if (go_rise)
                run <= ~run;
`else
            if (go_rise)
                run <= ~run;
`endif
        end
    end

    always_comb begin
        display = {5{8'h20}};
        if (sel)
            display = {two_digits(min), 8'h3A, two_digits(sec)};
    end

endmodule

// File: tb/tb_stopwatch_top.sv
// Scoreboarded bench for stopwatch_top: driver pushes expected display per cycle, monitor compares.
module tb_stopwatch_top;

    localparam int          TD  = 4;
    localparam logic [10:0] SEL = 11'b00001000000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        go = 1'b0;
    logic [10:0] op_code = 11'd0;
    logic [39:0] display;

    int errors = 0;
    int checks = 0;

    logic [39:0] exp_q[$];

    // Reference model: total running edges since reset plus run flag.
    int elapsed = 0;
    bit m_run = 1'b0;
    bit m_god = 1'b0;

    stopwatch_top #(.TICK_DIV(TD), .SEL_CODE(SEL)) dut (
        .clk(clk),
        .reset(reset),
        .go(go),
        .op_code(op_code),
        .display(display)
    );

    always #5 clk = ~clk;

    function automatic logic [39:0] model_disp(input bit s);
        int secs, m, sc;
        if (!s) return 40'h2020202020;
        secs = (elapsed / TD) % 3600;
        m  = secs / 60;
        sc = secs % 60;
        return {8'(48 + m / 10), 8'(48 + m % 10), 8'h3A, 8'(48 + sc / 10), 8'(48 + sc % 10)};
    endfunction

    // Drive one cycle's inputs after a negedge and predict the display seen at the following negedge.
    task automatic step(input bit r, input bit g, input logic [10:0] op, input int n = 1);
        bit s, rise;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
            reset = r;
            go = g;
            op_code = op;
            s = (op == SEL);
            if (r) begin
                elapsed = 0;
                m_run = 1'b0;
                m_god = 1'b0;
                #1;
                checks++;
                if (display !== model_disp(s)) begin
                    errors++;
                    $display("FAIL async_reset: got %h expected %h at %0t", display, model_disp(s), $time);
                end
            end else begin
                rise = g && !m_god && s;
                if (m_run) elapsed++;
                m_god = g;
`ifdef STOP_ON_DESELECT_EN
                if (!s) m_run = 1'b0;
                else if (rise) m_run = !m_run;
`else
                if (rise) m_run = !m_run;
`endif
            end
            exp_q.push_back(model_disp(s));
        end
    endtask

    initial begin : monitor
        logic [39:0] e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (display !== e) begin
                    errors++;
                    $display("FAIL display: got %h expected %h at %0t", display, e, $time);
                end
            end
        end
    end

    initial begin : driver
        logic [10:0] op;
        int k;
        // Reset, deselected, then selected with no go.
        step(1, 0, 11'd0);
        step(0, 0, 11'd0, 2);
        step(0, 0, SEL, 5);
        // Go held 3 cycles toggles once; count to 00:10 and beyond.
        step(0, 1, SEL, 3);
        step(0, 0, SEL, 45);
        // Pause/resume keeps partial second.
        step(1, 0, SEL);
        step(0, 1, SEL);
        step(0, 0, SEL, 5);
        step(0, 1, SEL);
        step(0, 0, SEL, 100);
        step(0, 1, SEL);
        step(0, 0, SEL, 6);
        // Deselect: go ignored, counting continues (or freezes with the stop option).
        step(0, 0, 11'd0, 3);
        step(0, 1, 11'd0, 2);
        step(0, 0, 11'd0, 10);
        step(0, 0, SEL, 10);
        // Multi-hot and near-miss codes are not selected.
        step(0, 1, SEL | 11'd1, 2);
        step(0, 0, SEL | 11'd1, 3);
        step(0, 0, SEL, 8);
        // Async reset mid-count, then restart from zero.
        step(1, 0, SEL);
        step(0, 0, SEL, 4);
        step(0, 1, SEL);
        step(0, 0, SEL, 10);
        // Full wrap: 59:59 then 00:00, passing 00:59 -> 01:00 on the way.
        step(1, 0, SEL);
        step(0, 1, SEL);
        step(0, 0, SEL, 3600 * TD + 3 * TD);
        // Stop exactly on a tick edge.
        k = TD - ((elapsed) % TD) - 1;
        if (k > 0) step(0, 0, SEL, k);
        step(0, 1, SEL);
        step(0, 0, SEL, 10);
        // Randomized phase.
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 5))
                0: op = 11'd0;
                1: op = SEL | 11'(1 << $urandom_range(0, 10));
                2: op = 11'($urandom);
                default: op = SEL;
            endcase
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) == 0), op);
        end
        step(0, 0, SEL, 2);
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
